// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: the send path that runs beside the PS/2 receiver on the
// keyboard port. It sends one command byte (for example 0xED set-LEDs or 0xFF reset) by pulling
// ps2_clk and ps2_data low through open-drain enables.
//
// Ports
//   clk           system clock (dot_clk)
//   rstn_i        asynchronous reset, active low
//   tx_data_i     byte to send; latched when tx_start_i is accepted
//   tx_start_i    one-cycle send request; accepted only while idle
//   ps2c_i        PS/2 clock pin level (asynchronous)
//   ps2d_i        PS/2 data pin level (asynchronous)
//   ps2c_oe_o     1 = pull PS/2 clock low, 0 = release
//   ps2d_oe_o     1 = pull PS/2 data low, 0 = release
//   tx_busy_o     high whenever a frame is in progress
//   tx_done_o     one-cycle pulse: frame sent and acknowledged by the device
//   tx_err_o      one-cycle pulse: timeout or missing acknowledge
//   rx_inhibit_o  mirrors tx_busy_o so the receiver ignores host-driven edges
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 800,
  parameter int unsigned TIMEOUT_CYCLES = 15760,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rstn_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe_o,
  output logic       ps2d_oe_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic       rx_inhibit_o
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [InhW-1:0] InhMax  = InhW'(INHIBIT_CYCLES);
  localparam logic [InhW-1:0] InhOne  = InhW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StRts, StSend, StAck, StWaitIdle
  } state_e;

  // Input conditioning: two-flop synchroniser, then a glitch filter that only changes the
  // filtered level once FILTER_LEN consecutive samples agree. Idle bus level is 1.
  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] c_shift_q, d_shift_q;
  logic                  c_filt_q, d_filt_q;
  logic                  fall;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      c_sync_q  <= '1;
      d_sync_q  <= '1;
      c_shift_q <= '1;
      d_shift_q <= '1;
      c_filt_q  <= 1'b1;
      d_filt_q  <= 1'b1;
    end else begin
      c_sync_q  <= {c_sync_q[0], ps2c_i};
      d_sync_q  <= {d_sync_q[0], ps2d_i};
      c_shift_q <= {c_shift_q[FILTER_LEN-2:0], c_sync_q[1]};
      d_shift_q <= {d_shift_q[FILTER_LEN-2:0], d_sync_q[1]};
      if (&c_shift_q)       c_filt_q <= 1'b1;
      else if (~|c_shift_q) c_filt_q <= 1'b0;
      if (&d_shift_q)       d_filt_q <= 1'b1;
      else if (~|d_shift_q) d_filt_q <= 1'b0;
    end
  end

  // Fall is flagged in the cycle the filter settles low, one clock before c_filt_q follows.
  assign fall = c_filt_q & ~|c_shift_q;

  state_e          state_q, state_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [3:0]      bit_q, bit_d;
  logic [8:0]      frame_q, frame_d;   // {parity, data}
  logic            d_low_q, d_low_d;   // level currently presented on data while sending
  logic            tmo_run, tmo_hit;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      inh_q   <= '0;
      tmo_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      d_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      d_low_q <= d_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    d_low_d   = d_low_q;
    ps2c_oe_o = 1'b0;
    ps2d_oe_o = 1'b0;
    tx_done_o = 1'b0;
    tx_err_o  = 1'b0;

    tmo_run = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitIdle);
    tmo_hit = tmo_run && !fall && (tmo_q >= TmoLast);
    if (tmo_run) begin
      if (fall)                 tmo_d = '0;
      else if (tmo_q != TmoMax) tmo_d = tmo_q + TmoOne;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_start_i) begin
          frame_d = {~^tx_data_i, tx_data_i};
          inh_d   = '0;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        ps2c_oe_o = 1'b1;
        if (inh_q >= InhLast) state_d = StRts;
        if (inh_q != InhMax)  inh_d   = inh_q + InhOne;
      end
      StRts: begin
        ps2c_oe_o = 1'b1;
        ps2d_oe_o = 1'b1;
        bit_d     = '0;
        tmo_d     = '0;
        d_low_d   = 1'b1;   // start bit stays on the line until the first device fall
        state_d   = StSend;
      end
      StSend: begin
        ps2d_oe_o = d_low_q;
        if (fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd9) begin
            d_low_d = ~frame_q[bit_q];
          end else begin
            d_low_d = 1'b0;   // stop bit: release data
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (fall) begin
          if (!d_filt_q) begin
            state_d = StWaitIdle;
          end else begin
            tx_err_o = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (c_filt_q && d_filt_q) begin
          tx_done_o = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort releases both lines in the same cycle the error pulse is raised.
    if (tmo_hit && !tx_done_o) begin
      state_d   = StIdle;
      tx_err_o  = 1'b1;
      ps2c_oe_o = 1'b0;
      ps2d_oe_o = 1'b0;
      d_low_d   = 1'b0;
    end
  end

  assign tx_busy_o    = (state_q != StIdle);
  assign rx_inhibit_o = tx_busy_o;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int Inh = 800;
  localparam int Tmo = 15760;
  localparam int H   = 30;   // device half clock period in system clocks

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       ps2c_line, ps2d_line;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err, rx_inhibit;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  // Open-drain bus: line is low if either side pulls it low.
  assign ps2c_line = !(ps2c_oe || dev_c_low);
  assign ps2d_line = !(ps2d_oe || dev_d_low);

  ps2_host_tx dut (
    .clk          (clk),
    .rstn_i       (rstn_i),
    .tx_data_i    (tx_data),
    .tx_start_i   (tx_start),
    .ps2c_i       (ps2c_line),
    .ps2d_i       (ps2d_line),
    .ps2c_oe_o    (ps2c_oe),
    .ps2d_oe_o    (ps2d_oe),
    .tx_busy_o    (tx_busy),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err),
    .rx_inhibit_o (rx_inhibit)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int mirror_bad = 0;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (rx_inhibit !== tx_busy) mirror_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: odd parity bit makes the total count of ones in data+parity odd.
  function automatic bit ref_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Measure the clock-inhibit phase and wait until the host releases the clock.
  task automatic dev_wait_send(input string tag);
    int cnt = 0;
    bit found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (ps2c_oe && ps2d_oe) break;
      if (ps2c_oe) cnt++;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, cnt, Inh);
    for (int i = 0; i < 20; i++) begin
      if (!ps2c_oe) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_send_entry"}, found, 1);
    check({tag, "_start_bit"}, ps2d_oe, 1);
  endtask

  // Device generates nbits clocks and samples data on each rising edge.
  task automatic dev_clock(input int nbits, input int glitch_at, output logic [9:0] bits);
    bits = '0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      dev_c_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_c_low = 1'b0;
      bits[k] = ps2d_line;
      if (k == glitch_at) begin
        repeat (15) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (H - 18) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic dev_ack(input bit give);
    if (give) begin
      dev_d_low = 1'b1;
      repeat (5) @(negedge clk);
    end
    dev_c_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_c_low = 1'b0;
    repeat (H) @(negedge clk);
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!tx_busy) break;
      @(negedge clk);
    end
    check({tag, "_idle"}, tx_busy, 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit ack,
                           input int glitch_at, input bit exp_par, input int exp_done,
                           input int exp_err);
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    dev_wait_send(tag);
    dev_clock(10, glitch_at, bits);
    dev_ack(ack);
    wait_idle(tag);
    @(negedge clk);
    check({tag, "_byte"}, bits[7:0], d);
    check({tag, "_parity"}, bits[8], exp_par);
    check({tag, "_stop"}, bits[9], 1);
    check({tag, "_done"}, done_cnt - d0, exp_done);
    check({tag, "_err"}, err_cnt - e0, exp_err);
    check({tag, "_released"}, {ps2c_oe, ps2d_oe}, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         glitch_at;
    bit         exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hED, 1'b1, -1, 1'b1, 1, 0};
    vecs[1] = '{8'hF4, 1'b1, -1, 1'b0, 1, 0};
    vecs[2] = '{8'h00, 1'b1, -1, 1'b1, 1, 0};
    vecs[3] = '{8'hA5, 1'b1,  4, 1'b1, 1, 0};   // glitch on clock mid-frame
    vecs[4] = '{8'h3C, 1'b0, -1, 1'b1, 0, 1};   // device omits ack

    repeat (3) @(negedge clk);
    check("reset_outputs", {ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err, rx_inhibit}, 0);
    rstn_i = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", {ps2c_oe, ps2d_oe, tx_busy}, 0);

    for (int v = 0; v < 5; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].ack, vecs[v].glitch_at,
                vecs[v].exp_par, vecs[v].exp_done, vecs[v].exp_err);
    end

    for (int r = 0; r < 6; r++) begin
      logic [7:0] d;
      bit ack;
      d   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", r), d, ack, -1, ref_parity(d), ack ? 1 : 0, ack ? 0 : 1);
    end

    // Device never clocks: abort after the timeout, both lines released with the error pulse.
    begin
      int n = 1;
      int d0;
      d0 = done_cnt;
      start_tx(8'h12);
      dev_wait_send("tmo");
      while (!tx_err && n < Tmo + 100) begin
        @(negedge clk);
        n++;
      end
      check("tmo_cycles", n, Tmo);
      check("tmo_oe_at_err", {ps2c_oe, ps2d_oe}, 0);
      @(negedge clk);
      check("tmo_idle", tx_busy, 0);
      check("tmo_no_done", done_cnt - d0, 0);
    end

    // Reset in the middle of a frame, with an ignored start request during SEND.
    begin
      logic [9:0] bits;
      start_tx(8'h00);
      dev_wait_send("rst");
      dev_clock(3, -1, bits);
      @(negedge clk);
      tx_data  = 8'h5A;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_start_ignored", {tx_busy, ps2c_oe, ps2d_oe}, 3'b101);
      rstn_i = 1'b0;
      #1;
      check("rst_async_outputs", {ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err}, 0);
      repeat (3) @(negedge clk);
      rstn_i = 1'b1;
      repeat (20) @(negedge clk);
      run_frame("post_rst", 8'hFF, 1'b1, -1, 1'b1, 1, 0);
    end

    check("done_err_exclusive", both_cnt, 0);
    check("inhibit_mirror", mirror_bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
